nios_fprint_irq_aggregator: RTL and testbench

//  Downstream consumer of the per-core interval timers and other single-bit interrupt sources.

---
 rtl/nios_fprint_irq_aggregator_pkg.sv | 26 ++
 rtl/nios_fprint_irq_src_slice.sv | 69 ++++++
 rtl/nios_fprint_irq_aggregator.sv | 115 +++++++++++
 tb/tb_nios_fprint_irq_aggregator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_fprint_irq_aggregator_pkg.sv
// Register map, ACTIVE field layout and the priority helper shared by the
// irq aggregator and its bench.
package nios_fprint_irq_aggregator_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] ADDR_PEND    = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_OVR     = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;
  localparam logic [2:0] ADDR_MISSCNT = 3'd6;

  localparam int ACTIVE_ANY_BIT = 15;
  localparam int ACTIVE_ID_W    = 4;

  // Lowest set index wins; an empty vector yields 0.
  function automatic logic [ACTIVE_ID_W-1:0] lowest_set(input logic [DATA_W-1:0] v);
    lowest_set = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ACTIVE_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/nios_fprint_irq_src_slice.sv
// One interrupt source: optional synchroniser, rising-edge detect, stored
// pending bit and sticky overrun flag.
module nios_fprint_irq_src_slice #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_i,
  input  logic edge_mode_i,
  input  logic w1c_i,
  input  logic force_i,
  input  logic ovr_w1c_i,
  output logic pend_eff_o,
  output logic ovr_o,
  output logic ovr_event_o
);

  logic s;
  logic prev_q;
  logic stored_q, stored_d;
  logic ovr_q, ovr_d;
  logic edge_det;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= irq_i;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign edge_det    = s & ~prev_q;
  // A W1C landing with a new edge hands the bit straight back, so no loss.
  assign ovr_event_o = edge_det & stored_q & ~w1c_i;

  always_comb begin
    stored_d = stored_q;
    if (w1c_i) stored_d = 1'b0;
    if (edge_det | force_i) stored_d = 1'b1;
    ovr_d = ovr_q;
    if (ovr_w1c_i) ovr_d = 1'b0;
    if (ovr_event_o) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= 1'b0;
      stored_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      prev_q   <= s;
      stored_q <= stored_d;
      ovr_q    <= ovr_d;
    end
  end

  assign pend_eff_o = edge_mode_i ? stored_q : s;
  assign ovr_o      = ovr_q;

endmodule

// File: rtl/nios_fprint_irq_aggregator.sv
// Avalon-MM slave collecting NUM_SRC interrupt lines into one prioritised,
// maskable irq_out for the Nios II, with overrun accounting.
module nios_fprint_irq_aggregator
  import nios_fprint_irq_aggregator_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq_out
);

  logic               wr;
  logic [NUM_SRC-1:0] w1c_vec, force_vec, ovr_w1c_vec;
  logic [NUM_SRC-1:0] pend_eff, ovr, ovr_event, active;
  logic [NUM_SRC-1:0] mask_q, edge_q;
  logic [15:0]        misscnt_q, misscnt_d;
  logic [15:0]        readdata_q, readdata_d;
  logic               irq_q;
  logic [15:0]        pend16, mask16, edge16, ovr16, active16;
  logic               any;
  logic [3:0]         id;
  logic               unused_wdata;

  assign wr          = chipselect & ~write_n;
  assign w1c_vec     = (wr && address == ADDR_PEND)  ? writedata[NUM_SRC-1:0] : '0;
  assign force_vec   = (wr && address == ADDR_FORCE) ? writedata[NUM_SRC-1:0] : '0;
  assign ovr_w1c_vec = (wr && address == ADDR_OVR)   ? writedata[NUM_SRC-1:0] : '0;
  assign unused_wdata = ^writedata;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      nios_fprint_irq_src_slice #(.SYNC_STAGES(SYNC_STAGES)) u_slice (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq_i       (irq_in[i]),
        .edge_mode_i (edge_q[i]),
        .w1c_i       (w1c_vec[i]),
        .force_i     (force_vec[i]),
        .ovr_w1c_i   (ovr_w1c_vec[i]),
        .pend_eff_o  (pend_eff[i]),
        .ovr_o       (ovr[i]),
        .ovr_event_o (ovr_event[i])
      );
    end
  endgenerate

  assign active = pend_eff & mask_q;
  assign any    = |active;

  always_comb begin
    pend16   = '0;
    mask16   = '0;
    edge16   = '0;
    ovr16    = '0;
    active16 = '0;
    pend16[NUM_SRC-1:0]   = pend_eff;
    mask16[NUM_SRC-1:0]   = mask_q;
    edge16[NUM_SRC-1:0]   = edge_q;
    ovr16[NUM_SRC-1:0]    = ovr;
    active16[NUM_SRC-1:0] = active;
  end

  assign id = lowest_set(active16);

  // Clear beats increment; the counter sticks at all-ones.
  always_comb begin
    misscnt_d = misscnt_q;
    if (wr && address == ADDR_MISSCNT) misscnt_d = '0;
    else if (|ovr_event && misscnt_q != 16'hFFFF) misscnt_d = misscnt_q + 16'd1;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_PEND:    readdata_d = pend16;
      ADDR_MASK:    readdata_d = mask16;
      ADDR_EDGE:    readdata_d = edge16;
      ADDR_ACTIVE: begin
        readdata_d[ACTIVE_ANY_BIT]       = any;
        readdata_d[ACTIVE_ID_W-1:0]      = id;
      end
      ADDR_OVR:     readdata_d = ovr16;
      ADDR_MISSCNT: readdata_d = misscnt_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      misscnt_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr && address == ADDR_MASK) mask_q <= writedata[NUM_SRC-1:0];
      if (wr && address == ADDR_EDGE) edge_q <= writedata[NUM_SRC-1:0];
      misscnt_q  <= misscnt_d;
      readdata_q <= readdata_d;
      irq_q      <= any;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_q;

endmodule

// File: tb/tb_nios_fprint_irq_aggregator.sv
// Bench for nios_fprint_irq_aggregator: table of register-level vectors plus
// directed multi-cycle sequences, reads scored through an expected queue.
module tb_nios_fprint_irq_aggregator;
  import nios_fprint_irq_aggregator_pkg::*;

  localparam int NUM_SRC = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [2:0]         address = '0;
  logic               chipselect = 1'b0;
  logic               write_n = 1'b1;
  logic [15:0]        writedata = '0;
  logic [15:0]        readdata;
  logic [NUM_SRC-1:0] irq_in = '0;
  logic               irq_out;

  nios_fprint_irq_aggregator #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        rd_issue = 1'b0;
  logic        rd_valid;

  typedef struct {
    logic [7:0]  edge_cfg;
    logic [7:0]  mask_cfg;
    logic [7:0]  pulse;
    logic [7:0]  level;
    logic [15:0] exp_pend;
    logic [15:0] exp_active;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Read data appears one clock after the address is presented.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_valid <= 1'b0;
    else          rd_valid <= rd_issue;
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_read: got %h expected none", readdata);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [15:0] exp, input string nm);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    rd_issue   = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    chipselect = 1'b0;
    rd_issue   = 1'b0;
  endtask

  task automatic clear_all(input logic [7:0] e, input logic [7:0] m);
    irq_in = '0;
    idle(1);
    wr_reg(ADDR_PEND, 16'h00FF);
    wr_reg(ADDR_OVR, 16'h00FF);
    wr_reg(ADDR_MISSCNT, 16'h0000);
    wr_reg(ADDR_EDGE, {8'h00, e});
    wr_reg(ADDR_MASK, {8'h00, m});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              edge   mask   pulse  level  pend      active    irq
    tbl[0] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 16'h0001, 16'h8000, 1'b1};
    tbl[1] = '{8'hFF, 8'h28, 8'h28, 8'h00, 16'h0028, 16'h8003, 1'b1};
    tbl[2] = '{8'hFF, 8'h00, 8'h81, 8'h00, 16'h0081, 16'h0000, 1'b0};
    tbl[3] = '{8'h0F, 8'hF0, 8'h00, 8'h30, 16'h0030, 16'h8004, 1'b1};
    tbl[4] = '{8'hF0, 8'hFF, 8'h40, 8'h06, 16'h0046, 16'h8001, 1'b1};
    tbl[5] = '{8'hFF, 8'h80, 8'hC0, 8'h00, 16'h00C0, 16'h8007, 1'b1};
    tbl[6] = '{8'h00, 8'hFF, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0};
    tbl[7] = '{8'hFF, 8'h7F, 8'h80, 8'h00, 16'h0080, 16'h0000, 1'b0};

    // Reset and idle register contents
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(1);
    check("reset_irq_out", {15'b0, irq_out}, 16'h0000);
    for (int a = 0; a < 8; a++) rd_reg(3'(a), 16'h0000, $sformatf("reset_rd_addr%0d", a));

    // Table vectors: one-clock pulse on edge sources, held level on level sources
    for (int i = 0; i < 8; i++) begin
      clear_all(tbl[i].edge_cfg, tbl[i].mask_cfg);
      irq_in = tbl[i].pulse | tbl[i].level;
      idle(1);
      irq_in = tbl[i].level;
      idle(1);
      check($sformatf("vec%0d_irq", i), {15'b0, irq_out}, {15'b0, tbl[i].exp_irq});
      rd_reg(ADDR_PEND, tbl[i].exp_pend, $sformatf("vec%0d_pend", i));
      rd_reg(ADDR_ACTIVE, tbl[i].exp_active, $sformatf("vec%0d_active", i));
    end

    // Edge latency and W1C release of irq_out
    clear_all(8'h01, 8'h01);
    irq_in = 8'h01;
    idle(1);
    check("edge_lat_1clk", {15'b0, irq_out}, 16'h0000);
    irq_in = 8'h00;
    idle(1);
    check("edge_lat_2clk", {15'b0, irq_out}, 16'h0001);
    rd_reg(ADDR_PEND, 16'h0001, "edge_pend");
    rd_reg(ADDR_ACTIVE, 16'h8000, "edge_active");
    wr_reg(ADDR_PEND, 16'h0001);
    check("w1c_irq_same_clk", {15'b0, irq_out}, 16'h0001);
    idle(1);
    check("w1c_irq_next_clk", {15'b0, irq_out}, 16'h0000);

    // Priority moves on after clearing the winner
    clear_all(8'hFF, 8'h28);
    irq_in = 8'h28;
    idle(1);
    irq_in = 8'h00;
    idle(1);
    rd_reg(ADDR_ACTIVE, 16'h8003, "prio_3_5");
    wr_reg(ADDR_PEND, 16'h0008);
    rd_reg(ADDR_ACTIVE, 16'h8005, "prio_after_w1c");

    // Overrun counting on source 2
    clear_all(8'hFF, 8'h04);
    for (int p = 0; p < 4; p++) begin
      irq_in = 8'h04;
      idle(1);
      irq_in = 8'h00;
      idle($urandom_range(1, 3));
    end
    rd_reg(ADDR_PEND, 16'h0004, "ovr_pend");
    rd_reg(ADDR_OVR, 16'h0004, "ovr_flag");
    rd_reg(ADDR_MISSCNT, 16'h0003, "misscnt_3");

    // Saturation: sources 2 and 3 alternate so one overrun lands every clock
    wr_reg(ADDR_FORCE, 16'h0008);
    for (int k = 0; k < 65600; k++) begin
      irq_in = (k % 2 == 1) ? 8'h04 : 8'h08;
      idle(1);
    end
    rd_reg(ADDR_MISSCNT, 16'hFFFF, "misscnt_sat");
    rd_reg(ADDR_OVR, 16'h000C, "ovr_two_src");
    irq_in = 8'h08;
    wr_reg(ADDR_MISSCNT, 16'h1234);
    irq_in = 8'h00;
    rd_reg(ADDR_MISSCNT, 16'h0000, "misscnt_clr_vs_inc");

    // W1C in the same clock as a new edge keeps the bit and is not an overrun
    clear_all(8'hFF, 8'hFF);
    wr_reg(ADDR_FORCE, 16'h0002);
    irq_in = 8'h02;
    wr_reg(ADDR_PEND, 16'h0002);
    irq_in = 8'h00;
    rd_reg(ADDR_PEND, 16'h0002, "w1c_vs_edge_pend");
    rd_reg(ADDR_OVR, 16'h0000, "w1c_vs_edge_ovr");
    rd_reg(ADDR_MISSCNT, 16'h0000, "w1c_vs_edge_cnt");
    // OVR clear in the same clock as a new overrun: overrun wins
    irq_in = 8'h02;
    wr_reg(ADDR_OVR, 16'h0002);
    irq_in = 8'h00;
    rd_reg(ADDR_OVR, 16'h0002, "ovr_clr_vs_set");
    rd_reg(ADDR_MISSCNT, 16'h0001, "ovr_clr_vs_set_cnt");

    // FORCE drives irq_out one clock after the write
    clear_all(8'hFF, 8'h80);
    wr_reg(ADDR_FORCE, 16'h0080);
    check("force_irq_write_clk", {15'b0, irq_out}, 16'h0000);
    idle(1);
    check("force_irq_next_clk", {15'b0, irq_out}, 16'h0001);
    rd_reg(ADDR_FORCE, 16'h0000, "force_reads_0");
    rd_reg(ADDR_PEND, 16'h0080, "force_pend");

    // Level mode: W1C has no effect, dropping the line releases irq_out
    clear_all(8'h00, 8'h10);
    irq_in = 8'h10;
    idle(2);
    check("level_irq_on", {15'b0, irq_out}, 16'h0001);
    wr_reg(ADDR_PEND, 16'h0010);
    rd_reg(ADDR_PEND, 16'h0010, "level_w1c_ignored");
    irq_in = 8'h00;
    idle(2);
    check("level_irq_off", {15'b0, irq_out}, 16'h0000);
    irq_in = 8'h10;
    idle(2);
    check("level_irq_again", {15'b0, irq_out}, 16'h0001);

    // Asynchronous reset mid-pending
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_irq", {15'b0, irq_out}, 16'h0000);
    check("async_reset_rdata", readdata, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    check("post_reset_irq", {15'b0, irq_out}, 16'h0000);
    rd_reg(ADDR_MASK, 16'h0000, "post_reset_mask");
    rd_reg(ADDR_PEND, 16'h0010, "post_reset_level_pend");
    wr_reg(ADDR_EDGE, 16'h0010);
    rd_reg(ADDR_PEND, 16'h0010, "post_reset_edge_stored");
    irq_in = 8'h00;

    idle(2);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
